// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and overflow/underflow pulses.
// FWFT=0: data_out registered, one cycle after an accepted read; FWFT=1: head word visible with zero latency.
`timescale 1ns/1ps
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_en,
    input  logic                         r_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_fifo_flags: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_flags: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH-1) begin : g_bad_ae
        $fatal(1, "sync_fifo_flags: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, underflow_q;
    logic                  rd_ok, wr_ok;

    // Explicit compare-and-wrap so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign rd_ok = r_en && !empty;
    assign wr_ok = w_en && (!full || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= w_en && !wr_ok;
            underflow_q <= r_en && !rd_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem_q[wr_ptr_q] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

        always_comb begin
            data_out_d = data_out_q;
            if (rd_ok) data_out_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge clk) begin
            if (rst) data_out_q <= '0;
            else     data_out_q <= data_out_d;
        end

        assign data_out = data_out_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a registered-read FIFO (depth 8) and an FWFT FIFO (depth 6) with the same stimulus.
// A queue-based model predicts state; read data goes through scoreboards checked by a monitor.
`timescale 1ns/1ps
module tb_sync_fifo_flags;

    localparam int A_D = 8, A_AF = 6, A_AE = 2;
    localparam int B_D = 6, B_AF = 5, B_AE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, w_en, r_en;
    logic [7:0] data_in;

    logic [7:0] a_dout, b_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [3:0] a_count;
    logic [2:0] b_count;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(A_D), .AF_THRESH(A_AF), .AE_THRESH(A_AE), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_udf)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(B_D), .AF_THRESH(B_AF), .AE_THRESH(B_AE), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_udf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] qa[$], qb[$];
    logic [7:0] sb_a[$], sb_b[$];

    int         nxt_cnt [2], exp_cnt [2];
    bit         nxt_ovf [2], exp_ovf [2];
    bit         nxt_udf [2], exp_udf [2];
    logic [7:0] nxt_adout = 8'h00, exp_adout = 8'h00;
    bit         exp_vld = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue bounded at the depth; acceptance follows the FIFO rules directly.
    task automatic predict(input int i, input int depth, input bit rs, input bit w, input bit r,
                           input logic [7:0] d);
        int n;
        bit rd_ok, wr_ok;
        logic [7:0] h;
        n = (i == 0) ? qa.size() : qb.size();
        if (rs) begin
            if (i == 0) begin qa.delete(); nxt_adout = 8'h00; end
            else qb.delete();
            nxt_cnt[i] = 0; nxt_ovf[i] = 1'b0; nxt_udf[i] = 1'b0;
            return;
        end
        rd_ok = r && (n > 0);
        wr_ok = w && ((n < depth) || rd_ok);
        if (rd_ok) begin
            if (i == 0) begin h = qa.pop_front(); sb_a.push_back(h); nxt_adout = h; end
            else begin h = qb.pop_front(); sb_b.push_back(h); end
        end
        if (wr_ok) begin
            if (i == 0) qa.push_back(d);
            else qb.push_back(d);
        end
        nxt_cnt[i] = n + int'(wr_ok) - int'(rd_ok);
        nxt_ovf[i] = w && !wr_ok;
        nxt_udf[i] = r && !rd_ok;
    endtask

    task automatic check_inst(input string p, input int cnt, input bit fu, input bit em,
                              input bit af, input bit ae, input bit ov, input bit un,
                              input int ec, input int depth, input int aft, input int aet,
                              input bit eov, input bit eun);
        chk({p, "_count"}, cnt, ec);
        chk({p, "_full"}, int'(fu), int'(ec == depth));
        chk({p, "_empty"}, int'(em), int'(ec == 0));
        chk({p, "_almost_full"}, int'(af), int'(ec >= aft));
        chk({p, "_almost_empty"}, int'(ae), int'(ec <= aet));
        chk({p, "_overflow"}, int'(ov), int'(eov));
        chk({p, "_underflow"}, int'(un), int'(eun));
    endtask

    // Inputs change on the falling edge; state from the previous rising edge is checked 4ns later.
    task automatic step(input bit rs, input bit w, input bit r, input logic [7:0] d);
        @(negedge clk);
        rst = rs; w_en = w; r_en = r; data_in = d;
        predict(0, A_D, rs, w, r, d);
        predict(1, B_D, rs, w, r, d);
        #4;
        if (exp_vld) begin
            check_inst("A", int'(a_count), a_full, a_empty, a_af, a_ae, a_ovf, a_udf,
                       exp_cnt[0], A_D, A_AF, A_AE, exp_ovf[0], exp_udf[0]);
            check_inst("B", int'(b_count), b_full, b_empty, b_af, b_ae, b_ovf, b_udf,
                       exp_cnt[1], B_D, B_AF, B_AE, exp_ovf[1], exp_udf[1]);
            chk("A_data_out_state", int'(a_dout), int'(exp_adout));
        end
        exp_vld   = 1'b1;
        exp_cnt   = nxt_cnt;
        exp_ovf   = nxt_ovf;
        exp_udf   = nxt_udf;
        exp_adout = nxt_adout;
    endtask

    // Monitor: registered FIFO shows data the cycle after an accepted read, FWFT during it.
    bit a_pend = 1'b0;
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (a_pend) begin
                if (sb_a.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL A_rdata: got 0x%0h, expected no read (scoreboard empty)", a_dout);
                end else begin
                    e = sb_a.pop_front();
                    chk("A_rdata", int'(a_dout), int'(e));
                end
            end
            a_pend = (rst === 1'b0) && (r_en === 1'b1) && (a_empty === 1'b0);
            if ((rst === 1'b0) && (r_en === 1'b1) && (b_empty === 1'b0)) begin
                if (sb_b.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL B_rdata: got 0x%0h, expected no read (scoreboard empty)", b_dout);
                end else begin
                    e = sb_b.pop_front();
                    chk("B_rdata", int'(b_dout), int'(e));
                end
            end
        end
    end

    initial begin
        int wp, rp;
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
        step(1, 0, 0, 8'h00);
        step(1, 1, 1, 8'hEE);
        step(0, 0, 0, 8'h00);

        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h10 + 8'(i));
        step(0, 1, 0, 8'hAA);
        step(0, 0, 0, 8'h00);
        step(0, 1, 1, 8'h55);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 1, 1, 8'h77);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);

        step(0, 1, 0, 8'h3C);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);

        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'hC0 + 8'(i));
        step(1, 1, 1, 8'hDD);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);

        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 8'(8'h40 + i));
            step(0, 0, 1, 8'h00);
        end

        for (int ph = 0; ph < 6; ph++) begin
            wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 25 : 55;
            rp = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 55;
            for (int c = 0; c < 120; c++)
                step($urandom_range(0, 79) == 0, $urandom_range(0, 99) < wp,
                     $urandom_range(0, 99) < rp, 8'($urandom));
        end

        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("A_scoreboard_drained", sb_a.size(), 0);
        chk("B_scoreboard_drained", sb_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the team's single-clock synchronous FIFO. It adds a live occupancy count, programmable almost-full and almost-empty thresholds, and overflow/underflow error pulses. A build-time mode selects either registered-read or first-word-fall-through (FWFT) output. It sits between a producer and a consumer in the same clock domain and is driven by the existing layered FIFO bench through an extended interface.

Parameters:
- DATA_WIDTH, 8, width of a stored word.
- DEPTH, 8, number of entries; any integer >= 2, power of two not required.
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- w_en  in  1  write request.
- r_en  in  1  read request (in FWFT mode, acknowledge of the head word).
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (sampled at posedge clk while rst=1), dominating w_en/r_en:
  - wr_ptr = rd_ptr = count = 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - data_out=0, overflow=0, underflow=0.
  - Storage array is not cleared.
- Read accepted (rd_ok) = r_en && !empty.
- Write accepted (wr_ok) = w_en && (!full || rd_ok). At full, a simultaneous read and write are both accepted and count stays DEPTH.
- At empty, a simultaneous write and read: the write is accepted, the read is rejected and underflow pulses. This holds in FWFT mode too.
- overflow = registered (w_en && !wr_ok). underflow = registered (r_en && !rd_ok). Each is high for exactly the cycle after the offending request.
- Pointers increment on their accept and wrap from DEPTH-1 to 0. Wrap must be correct for non-power-of-two DEPTH.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- All flags decode from the registered count. They change the cycle after the accept that moves count, with no combinational path from w_en/r_en.
- FWFT=0:
  - data_out is registered and loads mem[rd_ptr] on rd_ok, visible one cycle after the read request.
  - data_out holds its value when there is no accepted read, including after the FIFO drains.
- FWFT=1:
  - data_out = mem[rd_ptr] whenever empty=0, so the head word is visible with zero read latency.
  - A write to an empty FIFO makes empty fall one cycle later, with data_out already valid.
  - rd_ok pops the head; the next word appears in the same cycle the pointer advances.
  - data_out is don't-care while empty=1.
- Write data is stored at mem[wr_ptr] on wr_ok. A same-cycle read at full returns the old head, never the incoming word.
- Reset mid-operation discards all contents. The first post-reset read is an underflow unless a write is accepted first.
- Illegal parameters (DEPTH<2, thresholds out of range) stop elaboration with a $fatal.

Test Plan:
- Reset, then 8 writes 0x10..0x17 (DEPTH=8, AF=6, AE=2) -> count 1..8; almost_empty falls after the 3rd write; almost_full rises after the 6th; full after the 8th; no overflow.
- Full FIFO, a 9th write 0xAA -> overflow high for exactly 1 cycle, count stays 8; draining 8 reads returns 0x10..0x17 in order (FWFT=0: each word appears one cycle after r_en) and never 0xAA.
- Empty FIFO, r_en=1 for 1 cycle -> underflow pulses once, count stays 0, data_out unchanged.
- Full FIFO, w_en=r_en=1 with data 0x55 -> data_out=0x10, count stays 8, no overflow; 0x55 is read out last after 7 more pops.
- FWFT=1: single write 0x3C to an empty FIFO -> empty=0 and data_out=0x3C the next cycle with no r_en; r_en pops it and empty returns to 1.
- Write 5 words, assert rst for 1 cycle mid-stream -> count=0, empty=1, almost_empty=1, flags clear; wrap test of 20 write/read pairs at DEPTH=6 returns data in order.
